// File: rtl/decryption_core192_iter.sv
// Iterative AES-192 inverse cipher: forward key expansion into a 13-entry
// round-key file, then one inverse round per clock using round keys 12..0.
// Optional key cache skips the expansion when the same key is presented again.
module decryption_core192_iter #(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] key,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_LOADST, S_ROUND, S_DONE} state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [127:0]        out_q;
  logic [127:0]        ct_q;
  logic [127:0]        st_q;
  logic [191:0]        kx_q;
  logic [2:0]          cnt_q;
  logic [3:0]          r_q;
  logic                cache_valid_q;
  logic [191:0]        cached_key_q;
  logic [12:0][127:0]  rk_q;

  logic [7:0]          rcon_d;
  logic [191:0]        kx_d;
  logic [127:0]        rk_sel_d;
  logic [127:0]        ark_d;
  logic [127:0]        imc_d;
  logic                cache_hit_d;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward S-box: inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // One AES-192 schedule step over six 32-bit words
  function automatic logic [191:0] key_expansion_192(input logic [191:0] k, input logic [7:0] rc);
    logic [31:0] w [6];
    logic [31:0] t;
    logic [191:0] o;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    t = {sbox(w[5][23:16]), sbox(w[5][15:8]), sbox(w[5][7:0]), sbox(w[5][31:24])} ^ {rc, 24'h000000};
    w[0] = w[0] ^ t;
    for (int i = 1; i < 6; i++) w[i] = w[i] ^ w[i-1];
    o = '0;
    for (int i = 0; i < 6; i++) o[191-32*i -: 32] = w[i];
    return o;
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared datapath: one schedule step and one inverse round per cycle
  assign rcon_d      = 8'h01 << cnt_q;
  assign kx_d        = key_expansion_192(kx_q, rcon_d);
  assign rk_sel_d    = rk_q[r_q];
  assign ark_d       = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel_d;
  assign imc_d       = inv_mix_columns(ark_d);
  assign cache_hit_d = (KEY_CACHE != 0) && cache_valid_q && (key == cached_key_q);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

  // Control FSM with registered outputs; also owns key file, state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_q         <= '0;
      ct_q          <= '0;
      st_q          <= '0;
      kx_q          <= '0;
      cnt_q         <= 3'd0;
      r_q           <= 4'd0;
      cache_valid_q <= 1'b0;
      cached_key_q  <= '0;
      rk_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            ct_q       <= in;
            kx_q       <= key;
            if (cache_hit_d) begin
              state_q <= S_LOADST;
            end else begin
              // Cache stays invalid until the whole key file has been rewritten
              state_q       <= S_KEXP;
              cnt_q         <= 3'd0;
              cache_valid_q <= 1'b0;
              cached_key_q  <= key;
              rk_q[0]       <= key[191:64];
            end
          end
        end
        S_KEXP: begin
          kx_q <= kx_d;
          // Even steps straddle two round keys, odd steps fill one
          case (cnt_q)
            3'd0: begin rk_q[1]  <= {kx_q[63:0], kx_d[191:128]}; rk_q[2]  <= kx_d[127:0]; end
            3'd1: rk_q[3] <= kx_d[191:64];
            3'd2: begin rk_q[4]  <= {kx_q[63:0], kx_d[191:128]}; rk_q[5]  <= kx_d[127:0]; end
            3'd3: rk_q[6] <= kx_d[191:64];
            3'd4: begin rk_q[7]  <= {kx_q[63:0], kx_d[191:128]}; rk_q[8]  <= kx_d[127:0]; end
            3'd5: rk_q[9] <= kx_d[191:64];
            3'd6: begin rk_q[10] <= {kx_q[63:0], kx_d[191:128]}; rk_q[11] <= kx_d[127:0]; end
            default: rk_q[12] <= kx_d[191:64];
          endcase
          if (cnt_q == 3'd7) begin
            st_q          <= ct_q ^ kx_d[191:64];
            cache_valid_q <= (KEY_CACHE != 0);
            r_q           <= 4'd11;
            state_q       <= S_ROUND;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_LOADST: begin
          st_q    <= ct_q ^ rk_q[12];
          r_q     <= 4'd11;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (r_q != 4'd0) begin
            st_q <= imc_d;
            r_q  <= r_q - 4'd1;
          end else begin
            // Final round has no InvMixColumns
            out_q       <= ark_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_core192_iter.sv
// Scoreboard bench for decryption_core192_iter: the driver pushes expected
// plaintext and latency at each accept, a negedge monitor pops and compares.
module tb_decryption_core192_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [191:0] key = '0;
  logic [127:0] din = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] dout;
  logic         busy;

  logic         in_valid0 = 1'b0;
  logic         in_ready0;
  logic         out_valid0;
  logic         out_ready0 = 1'b1;
  logic [127:0] dout0;
  logic         busy0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [191:0] K1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] K3 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] C3 = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [7:0] sbox_t [256];

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb [$];

  bit           mcache_v = 1'b0;
  logic [191:0] mcache_k = '0;
  bit           rand_mode = 1'b0;
  int           hold_cycles = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  decryption_core192_iter #(.KEY_CACHE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .in(din), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .busy(busy));

  decryption_core192_iter #(.KEY_CACHE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .key(key), .in(din), .out_valid(out_valid0), .out_ready(out_ready0),
    .out(dout0), .busy(busy0));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference FIPS-197 AES-192 forward cipher, table-driven
  function automatic logic [127:0] aes192_enc(input logic [191:0] k, input logic [127:0] pt);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_t[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      if (r < 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = u[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block, wait (bounded) for acceptance, record the expectation
  task automatic send(input logic [191:0] k, input logic [127:0] c, input logic [127:0] p);
    exp_t e;
    int   n;
    @(negedge clk);
    key = k; din = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", n);
      in_valid = 1'b0;
      return;
    end
    e.pt  = p;
    e.acc = cyc + 1;
    e.lat = (mcache_v && mcache_k == k) ? 13 : 20;
    mcache_v = 1'b1;
    mcache_k = k;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key = rnd192();
    din = rnd128();
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // In_valid pulses with junk data while the core cannot accept
  task automatic noise();
    int g;
    g = $urandom_range(0, 4);
    for (int j = 0; j < g; j++) begin
      @(negedge clk);
      if (!in_ready) begin
        in_valid = 1'b1; key = rnd192(); din = rnd128();
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // Monitor: compare on first sight of out_valid, check hold and release behaviour
  exp_t         mon_e;
  bit           pending = 1'b0;
  bit           hs_prev = 1'b0;
  logic [127:0] held = '0;
  int           hold_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      hs_prev = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hs_prev) begin
        chki("out_valid_fall", int'(out_valid), 0);
        chki("in_ready_after_hs", int'(in_ready), 1);
        hs_prev = 1'b0;
      end
      if (out_valid) begin
        if (!pending) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got %h with empty scoreboard", dout);
          end else begin
            mon_e = sb.pop_front();
            chk("plaintext", dout, mon_e.pt);
            chki("latency", cyc - mon_e.acc, mon_e.lat);
          end
          pending = 1'b1;
          held = dout;
          hold_left = hold_cycles;
        end else begin
          chk("out_stable", dout, held);
          chki("in_ready_in_done", int'(in_ready), 0);
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          hs_prev = 1'b1;
          pending = 1'b0;
        end
      end else begin
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] k;
    logic [191:0] last_k;
    logic [127:0] p;
    int           acc0;
    int           n;

    for (int i = 0; i < 256; i++) sbox_t[i] = SBOX_HEX[2047-8*i -: 8];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chki("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", dout, 128'h0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;

    // T1 full expansion, T2 cache hit, T3 new key
    send(K1, C1, P1);
    wait_drain(100);
    send(K1, C1, P1);
    wait_drain(100);
    send(K3, C3, P3);
    wait_drain(100);

    // T4 consumer stalls five cycles
    hold_cycles = 5;
    send(K3, C3, P3);
    wait_drain(100);
    hold_cycles = 0;
    repeat (8) @(negedge clk);

    // T5 reset at round 6 of a fresh expansion
    send(K1, C1, P1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    chki("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chki("abort_out_valid", int'(out_valid), 0);
    chk("abort_out", dout, 128'h0);
    chki("abort_busy", int'(busy), 0);
    chki("abort_in_ready", int'(in_ready), 0);
    if (sb.size() > 0) void'(sb.pop_back());
    mcache_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(K1, C1, P1);
    wait_drain(100);

    // T6 random traffic with junk offers while busy and random consumer gaps
    rand_mode = 1'b1;
    last_k = K1;
    for (int t = 0; t < 500; t++) begin
      k = ($urandom_range(0, 7) == 0) ? last_k : rnd192();
      p = rnd128();
      last_k = k;
      noise();
      send(k, aes192_enc(k, p), p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain(300);
    rand_mode = 1'b0;
    repeat (5) @(negedge clk);

    // Cache disabled: the same key always re-expands
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      key = K1; din = C1; in_valid0 = 1'b1;
      n = 0;
      while (!in_ready0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      acc0 = cyc + 1;
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      key = rnd192();
      din = rnd128();
      n = 0;
      while (!out_valid0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chki("nocache_latency", cyc - acc0, 20);
      chk("nocache_plaintext", dout0, P1);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
